// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings for the DMEM load/store sequencer: access sizes, FSM states
// and the alignment rule used when a request is accepted.
package dmem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

  // The reserved size code is always reported as an alignment fault.
  function automatic logic is_misaligned(input size_t sz, input logic [1:0] lane);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      SZ_WORD: return |lane;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_mux.sv
// Little-endian lane steering: extracts a right-aligned, zero-filled load value
// from a DMEM word and merges right-aligned store data into that word.
module dmem_lane_mux
  import dmem_access_ctrl_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  size_t       i_size,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_merged
);

  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;
  logic [31:0] w_mask;

  // Half accesses are aligned, so 8*addr[1:0] also selects the correct half.
  assign w_shamt   = {i_lane, 3'b000};
  assign w_shifted = i_word >> w_shamt;

  always_comb begin
    o_rdata = 32'h0;
    w_mask  = 32'h0;
    case (i_size)
      SZ_BYTE: begin
        o_rdata = {24'h0, w_shifted[7:0]};
        w_mask  = 32'h0000_00FF << w_shamt;
      end
      SZ_HALF: begin
        o_rdata = {16'h0, w_shifted[15:0]};
        w_mask  = 32'h0000_FFFF << w_shamt;
      end
      SZ_WORD: begin
        o_rdata = i_word;
        w_mask  = 32'hFFFF_FFFF;
      end
      default: ;
    endcase
  end

  assign o_merged = (i_word & ~w_mask) | ((i_wdata << w_shamt) & w_mask);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the CPU datapath and word-wide DMEM: alignment
// check, req/ready DMEM handshake, read-modify-write for sub-word stores.
// DMEM handshake: mem_en with stable mem_addr/mem_we/mem_wdata is held until a
// cycle where mem_ready=1; that cycle completes the transfer (mem_rdata valid on reads).
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int WAIT_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              misalign_err,
  output logic              bus_err,
  output logic [31:0]       rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output state_t            dbg_state
);

  localparam int               CNT_W   = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(WAIT_LIMIT);

  state_t              r_state;
  logic                r_we;
  size_t               r_size;
  logic [1:0]          r_lane;
  logic [31:0]         r_wdata;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_done;
  logic                r_misalign;
  logic                r_bus_err;
  logic [31:0]         r_rdata;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;

  logic [31:0]         w_extract;
  logic [31:0]         w_merged;
  logic                w_limit_hit;
  logic                w_unused;

  assign w_unused = &{1'b0, addr[31:ADDR_W+2]};

  dmem_lane_mux u_lane_mux (
    .i_word   (mem_rdata),
    .i_lane   (r_lane),
    .i_size   (r_size),
    .i_wdata  (r_wdata),
    .o_rdata  (w_extract),
    .o_merged (w_merged)
  );

  // A limit of zero disables the abandon path entirely.
  assign w_limit_hit = (WAIT_LIMIT != 0) && (r_cnt == LIMIT_V);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_size      <= SZ_BYTE;
      r_lane      <= 2'b00;
      r_wdata     <= 32'h0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
      r_rdata     <= 32'h0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'h0;
    end else begin
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_we        <= we;
            r_size      <= size_t'(size);
            r_lane      <= addr[1:0];
            r_wdata     <= wdata;
            r_mem_addr  <= addr[ADDR_W+1:2];
            r_mem_wdata <= wdata;
            r_cnt       <= '0;
            if (is_misaligned(size_t'(size), addr[1:0])) begin
              r_state    <= ST_RESP;
              r_done     <= 1'b1;
              r_misalign <= 1'b1;
            end else if (we && size_t'(size) == SZ_WORD) begin
              r_state  <= ST_WRITE;
              r_mem_en <= 1'b1;
              r_mem_we <= 1'b1;
            end else begin
              r_state  <= ST_READ;
              r_mem_en <= 1'b1;
              r_mem_we <= 1'b0;
            end
          end
        end
        ST_READ, ST_WRITE: begin
          if (mem_ready) begin
            r_cnt <= '0;
            if (r_state == ST_READ && r_we) begin
              // Sub-word store: old word read, now write back the merged word.
              r_mem_wdata <= w_merged;
              r_mem_we    <= 1'b1;
              r_state     <= ST_WRITE;
            end else begin
              if (r_state == ST_READ) r_rdata <= w_extract;
              r_mem_en <= 1'b0;
              r_mem_we <= 1'b0;
              r_state  <= ST_RESP;
              r_done   <= 1'b1;
            end
          end else if (w_limit_hit) begin
            r_mem_en  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= ST_RESP;
            r_done    <= 1'b1;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy         = (r_state != ST_IDLE);
  assign done         = r_done;
  assign misalign_err = r_misalign;
  assign bus_err      = r_bus_err;
  assign rdata        = r_rdata;
  assign mem_en       = r_mem_en;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: byte-array DMEM responder with programmable wait
// states, directed vector table, reset-mid-access sequence and randomized traffic.
module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata, mem_wdata, mem_rdata;
  logic        busy, done, misalign_err, bus_err, mem_en, mem_we, mem_ready;
  logic [10:0] mem_addr;
  state_t      dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // DMEM model: byte array as seen through the bus, plus a reference image.
  logic [7:0]  mem_b [0:8191];
  logic [7:0]  ref_b [0:8191];
  logic [12:0] mbase;
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  int          en_cycles = 0;
  logic [31:0] exp_rdata = 32'h0;

  dmem_access_ctrl #(.ADDR_W(11), .WAIT_LIMIT(15)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .misalign_err(misalign_err),
    .bus_err(bus_err), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- DMEM responder ----------------
  assign mbase = {mem_addr, 2'b00};

  always @(negedge clk) begin
    if (mem_en === 1'b1 && wait_cnt >= wait_cfg) begin
      mem_ready = 1'b1;
      mem_rdata = {mem_b[mbase+3], mem_b[mbase+2], mem_b[mbase+1], mem_b[mbase]};
    end else begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
  end

  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      en_cycles++;
      if (mem_ready) begin
        if (mem_we) for (int i = 0; i < 4; i++) mem_b[mbase+i] = mem_wdata[8*i +: 8];
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [12:0] a);
    logic [12:0] b;
    b = {a[12:2], 2'b00};
    return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
  endfunction

  function automatic logic [31:0] dmem_word(input logic [12:0] a);
    logic [12:0] b;
    b = {a[12:2], 2'b00};
    return {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
  endfunction

  task automatic set_word(input logic [12:0] a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      mem_b[a+i] = v[8*i +: 8];
      ref_b[a+i] = v[8*i +: 8];
    end
  endtask

  // Reference model: size n = 2**size bytes, little-endian byte arithmetic.
  function automatic bit ref_misaligned(input logic [1:0] sz, input logic [31:0] a);
    int nb;
    nb = 1 << sz;
    return (sz == 2'b11) || ((a % nb) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] v;
    logic [12:0] b;
    v = 32'h0;
    b = a[12:0];
    for (int i = 0; i < (1 << sz); i++) v = v | (32'(ref_b[b+i]) << (8*i));
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    logic [12:0] b;
    b = a[12:0];
    for (int i = 0; i < (1 << sz); i++) ref_b[b+i] = wd[8*i +: 8];
  endtask

  // ---------------- driver ----------------
  task automatic run_access(input logic w, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input int wcfg, input bit hold,
                            output int lat, output logic mis, output logic be,
                            output logic [31:0] rd, output int en_cyc, output bit glitch);
    int guard;
    int en_base;
    guard = 0;
    while (busy && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    wait_cfg = wcfg;
    en_base  = en_cycles;
    req = 1'b1; we = w; size = sz; addr = a; wdata = wd;
    @(posedge clk); #1;
    we = $urandom; size = $urandom; addr = $urandom; wdata = $urandom;
    lat = 1;
    glitch = 1'b0;
    while (!done && lat < 60) begin
      req = hold;
      if (misalign_err || bus_err || !busy) glitch = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    req = 1'b0;
    mis = misalign_err;
    be  = bus_err;
    rd  = rdata;
    en_cyc = en_cycles - en_base;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    int          wcfg;
    int          lat;
    logic        mis;
    logic        be;
    logic [31:0] rd;
    int          en;
  } vec_t;

  vec_t vt[$];

  initial begin
    int          lat, en_cyc, nb, phases, exp_lat, exp_en;
    logic        mis, be, w;
    logic [1:0]  sz;
    logic [31:0] a, wd, rd;
    bit          glitch, saw_done, exp_mis, exp_be;
    int          wcfg;

    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; addr = 32'h0; wdata = 32'h0;
    for (int i = 0; i < 8192; i++) begin
      mem_b[i] = 8'($urandom);
      ref_b[i] = mem_b[i];
    end
    set_word(13'h10, 32'h89AB_CDEF);
    set_word(13'h20, 32'h1122_3344);
    set_word(13'h40, 32'hDEAD_BEEF);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ctrl", {26'h0, busy, done, misalign_err, bus_err, mem_en, mem_we}, 32'h0);
    chk("rst_mem_addr", {21'h0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
    rst = 1'b0;

    //            w  sz  addr   wdata          wait lat mis be rdata          en
    vt.push_back('{0, 2, 'h10, 'h0,           0,   2,  0,  0, 'h89ABCDEF,   1});
    vt.push_back('{0, 0, 'h13, 'h0,           0,   2,  0,  0, 'h00000089,   1});
    vt.push_back('{0, 1, 'h12, 'h0,           0,   2,  0,  0, 'h000089AB,   1});
    vt.push_back('{0, 0, 'h10, 'h0,           0,   2,  0,  0, 'h000000EF,   1});
    vt.push_back('{0, 1, 'h10, 'h0,           1,   3,  0,  0, 'h0000CDEF,   2});
    vt.push_back('{1, 0, 'h21, 'h55,          0,   3,  0,  0, 'h0000CDEF,   2});
    vt.push_back('{0, 2, 'h20, 'h0,           0,   2,  0,  0, 'h11225544,   1});
    vt.push_back('{1, 1, 'h03, 'h1234,        0,   1,  1,  0, 'h11225544,   0});
    vt.push_back('{0, 2, 'h11, 'h0,           0,   1,  1,  0, 'h11225544,   0});
    vt.push_back('{0, 3, 'h10, 'h0,           0,   1,  1,  0, 'h11225544,   0});
    vt.push_back('{1, 1, 'h22, 'hFFFFBEEF,    0,   3,  0,  0, 'h11225544,   2});
    vt.push_back('{0, 2, 'h20, 'h0,           0,   2,  0,  0, 'hBEEF5544,   1});
    vt.push_back('{1, 2, 'h30, 'hCAFEF00D,    0,   2,  0,  0, 'hBEEF5544,   1});
    vt.push_back('{0, 2, 'h30, 'h0,           0,   2,  0,  0, 'hCAFEF00D,   1});
    vt.push_back('{0, 2, 'h10, 'h0,           15,  17, 0,  0, 'h89ABCDEF,   16});
    vt.push_back('{0, 2, 'h30, 'h0,           16,  17, 0,  1, 'h89ABCDEF,   16});
    vt.push_back('{1, 2, 'h30, 'h0,           99,  17, 0,  1, 'h89ABCDEF,   16});
    vt.push_back('{0, 2, 'h30, 'h0,           0,   2,  0,  0, 'hCAFEF00D,   1});
    vt.push_back('{1, 0, 'h33, 'h1A5,         2,   7,  0,  0, 'hCAFEF00D,   6});
    vt.push_back('{0, 2, 'h30, 'h0,           0,   2,  0,  0, 'hA5FEF00D,   1});
    vt.push_back('{0, 1, 'h32, 'h0,           1,   3,  0,  0, 'h0000A5FE,   2});
    vt.push_back('{1, 0, 'h20, 'h77,          15,  33, 0,  0, 'h0000A5FE,   32});
    vt.push_back('{0, 2, 'h20, 'h0,           0,   2,  0,  0, 'hBEEF5577,   1});

    foreach (vt[k]) begin
      run_access(vt[k].w, vt[k].sz, vt[k].a, vt[k].wd, vt[k].wcfg, 1'b0,
                 lat, mis, be, rd, en_cyc, glitch);
      chk($sformatf("vec%0d_latency", k), lat, vt[k].lat);
      chk($sformatf("vec%0d_misalign", k), {31'h0, mis}, {31'h0, vt[k].mis});
      chk($sformatf("vec%0d_bus_err", k), {31'h0, be}, {31'h0, vt[k].be});
      chk($sformatf("vec%0d_rdata", k), rd, vt[k].rd);
      chk($sformatf("vec%0d_mem_en_cycles", k), en_cyc, vt[k].en);
      chk($sformatf("vec%0d_flags_before_done", k), {31'h0, glitch}, 32'h0);
      if (vt[k].w && !vt[k].mis && !vt[k].be) ref_store(vt[k].sz, vt[k].a, vt[k].wd);
    end
    exp_rdata = 32'hBEEF5577;

    // reset while a word store waits in WRITE
    while (busy) begin @(posedge clk); #1; end
    wait_cfg = 99;
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h40; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rstseq_waiting_en", {31'h0, mem_en}, 32'h1);
    chk("rstseq_waiting_state", {30'h0, dbg_state}, {30'h0, ST_WRITE});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rdata = 32'h0;
    chk("rstseq_mem_en", {31'h0, mem_en}, 32'h0);
    chk("rstseq_busy", {31'h0, busy}, 32'h0);
    chk("rstseq_done", {31'h0, done}, 32'h0);
    chk("rstseq_rdata", rdata, exp_rdata);
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || mem_en) saw_done = 1'b1;
    end
    chk("rstseq_quiet_after", {31'h0, saw_done}, 32'h0);
    chk("rstseq_no_write", dmem_word(13'h40), ref_word(13'h40));
    run_access(1'b0, 2'b10, 32'h10, 32'h0, 0, 1'b0, lat, mis, be, rd, en_cyc, glitch);
    chk("rstseq_lw_latency", lat, 2);
    chk("rstseq_lw_rdata", rd, 32'h89AB_CDEF);
    chk("rstseq_lw_errs", {30'h0, mis, be}, 32'h0);
    exp_rdata = 32'h89AB_CDEF;

    // randomized traffic against the byte-level reference model
    for (int t = 0; t < 200; t++) begin
      w    = 1'($urandom);
      sz   = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a    = ($urandom & 32'hFFFF_E000) | 32'($urandom_range(0, 63));
      wd   = $urandom;
      wcfg = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 2) : $urandom_range(14, 17);

      exp_mis = ref_misaligned(sz, a);
      exp_be  = !exp_mis && (wcfg > 15);
      phases  = (w && sz != 2'b10) ? 2 : 1;
      if (exp_mis) begin
        exp_lat = 1; exp_en = 0;
      end else if (exp_be) begin
        exp_lat = 17; exp_en = 16;
      end else begin
        exp_lat = 1 + phases * (wcfg + 1);
        exp_en  = phases * (wcfg + 1);
      end
      if (!exp_mis && !exp_be) begin
        if (w) ref_store(sz, a, wd);
        else   exp_rdata = ref_load(sz, a);
      end

      run_access(w, sz, a, wd, wcfg, ($urandom_range(0, 3) == 0),
                 lat, mis, be, rd, en_cyc, glitch);
      chk($sformatf("rnd%0d_latency", t), lat, exp_lat);
      chk($sformatf("rnd%0d_errs", t), {30'h0, mis, be}, {30'h0, exp_mis, exp_be});
      chk($sformatf("rnd%0d_rdata", t), rd, exp_rdata);
      chk($sformatf("rnd%0d_mem_en_cycles", t), en_cyc, exp_en);
      chk($sformatf("rnd%0d_flags_before_done", t), {31'h0, glitch}, 32'h0);
      if (w) chk($sformatf("rnd%0d_mem_word", t), dmem_word(a[12:0]), ref_word(a[12:0]));
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
